// File: rtl/divider.sv
// divider: 32-bit unsigned restoring divider, one quotient bit per clock.
//
// subtract ports:
//   a_i, b_i  minuend / subtrahend
//   diff_o    a_i - b_i (modulo 2^W)
//   ovf_o     borrow out (a_i < b_i)
//
// divider ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request a divide; a/b sampled with it in IDLE or DONE
//   a, b         unsigned dividend / divisor
//   busy         high while the 32 restoring steps are running
//   done         one-cycle pulse; c/r/div_by_zero valid
//   c, r         quotient / remainder, held until the next completion
//   div_by_zero  last completed divide had b == 0 (c = all ones, r = a)

module subtract #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             ovf_o
);
    assign {ovf_o, diff_o} = {1'b0, a_i} - {1'b0, b_i};
endmodule

module divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] r,
    output logic             div_by_zero
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d, b_q, b_d, rem_q, rem_d, quo_q, quo_d;
    logic [WIDTH-1:0] c_q, c_d, r_q, r_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             accept;

    // The shifted value can reach 33 bits, but whenever it is >= b the true
    // difference is < b and so fits in 32 bits: the low 32 bits of the
    // subtractor are exact and its borrow is not needed.
    assign shifted = {rem_q, dvd_q[WIDTH-1]};
    assign accept  = shifted >= {1'b0, b_q};

    subtract #(.WIDTH(WIDTH)) u_sub (
        .a_i   (shifted[WIDTH-1:0]),
        .b_i   (b_q),
        .diff_o(diff),
        .ovf_o ()
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        b_d     = b_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        c_d     = c_q;
        r_d     = r_q;
        dbz_d   = dbz_q;
        if (state_q == RUN) begin
            rem_d = accept ? diff : shifted[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], accept};
            dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
            cnt_d = (cnt_q == 5'd0) ? cnt_q : cnt_q - 5'd1;
            if (cnt_q == 5'd0) begin
                state_d = DONE;
                c_d     = quo_d;
                r_d     = rem_d;
                dbz_d   = 1'b0;
            end
        end else if (start) begin
            dvd_d   = a;
            b_d     = b;
            rem_d   = '0;
            quo_d   = '0;
            cnt_d   = 5'd31;
            state_d = (b == '0) ? DONE : RUN;
            if (b == '0) begin
                c_d   = '1;
                r_d   = a;
                dbz_d = 1'b1;
            end
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            c_q     <= '0;
            r_q     <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            c_q     <= c_d;
            r_q     <= r_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = state_q == RUN;
    assign done        = state_q == DONE;
    assign c           = c_q;
    assign r           = r_q;
    assign div_by_zero = dbz_q;
endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width; only 32 is supported.
REQ-002 SHALL have port: clk  input  1  single clock, rising-edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start  input  1  request a divide; sampled on rising clk.
REQ-005 SHALL have port: a  input  32  unsigned dividend; sampled with start.
REQ-006 SHALL have port: b  input  32  unsigned divisor; sampled with start.
REQ-007 SHALL have port: busy  output  1  high while a divide is in progress.
REQ-008 SHALL have port: done  output  1  one-cycle pulse; results valid.
REQ-009 SHALL have port: c  output  32  quotient.
REQ-010 SHALL have port: r  output  32  remainder.
REQ-011 SHALL have port: div_by_zero  output  1  last completed divide had b == 0.

Function
REQ-012 SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-013 SHALL accept start only in IDLE or DONE; on the accepting edge N it SHALL latch a and b.
REQ-014 SHALL, on acceptance with b != 0, enter RUN, clear the partial remainder and load the iteration counter with 31.
REQ-015 SHALL, on acceptance with b == 0, enter DONE directly at edge N (no RUN cycles).
REQ-016 SHALL, in RUN, perform one restoring step per clock: shift {partial remainder, dividend MSB} left by one, trial-subtract the divisor, accept when the 33-bit shifted value >= divisor, and shift the quotient bit (1 on accept, 0 otherwise) into the quotient register.
REQ-017 SHALL obtain the 32-bit trial difference from an instance of the team's subtract module; the accept decision SHALL be the unsigned 33-bit compare, independent of that module's overflow output.
REQ-018 SHALL leave RUN for DONE after exactly 32 steps, at edge N+32.
REQ-019 SHALL hold busy high from edge N until the edge on which DONE is entered, and low otherwise.
REQ-020 SHALL assert done for exactly the one cycle spent in DONE: after edge N+32 (b != 0) or after edge N (b == 0).
REQ-021 SHALL update c, r and div_by_zero only on the edge that enters DONE, and hold them until the next completion.
REQ-022 SHALL, for b == 0, produce c = 0xFFFFFFFF, r = a and div_by_zero = 1.
REQ-023 SHALL, for b != 0, produce div_by_zero = 0 and c, r satisfying a == c*b + r with r < b.
REQ-024 SHALL return from DONE to IDLE on the next edge unless start is high, in which case it SHALL accept the new operands (back-to-back).
REQ-025 SHALL ignore start while in RUN; the operands and the count in progress SHALL be unaffected.
REQ-026 SHALL keep the iteration counter in the range 31..0 with no wrap-around; the RUN-to-DONE transition SHALL occur on count 0.

Reset
REQ-027 SHALL, while rst_n is low, immediately force state IDLE and busy = 0, done = 0, c = 0, r = 0, div_by_zero = 0, and clear all internal registers.
REQ-028 SHALL, on rst_n assertion mid-RUN, abort the operation with no done pulse; the first start after release SHALL behave as a fresh divide.

Verification
REQ-029 SHALL be verified by this scenario: a = 100, b = 7, start for 1 cycle -> busy for 32 cycles, then done pulse with c = 14, r = 2, div_by_zero = 0.
REQ-030 SHALL be verified by this scenario: a = 0xFFFFFFFF, b = 1 -> c = 0xFFFFFFFF, r = 0; and a = 3, b = 10 -> c = 0, r = 3.
REQ-031 SHALL be verified by this scenario: a = 5, b = 0 -> done in the cycle after acceptance, c = 0xFFFFFFFF, r = 5, div_by_zero = 1, busy never high.
REQ-032 SHALL be verified by this scenario: a = 100, b = 7 started, then start with a = 9, b = 3 pulsed at step 10 -> ignored; result c = 14, r = 2.
REQ-033 SHALL be verified by this scenario: start held high through DONE with a = 9, b = 3 -> second divide accepted back-to-back, c = 3, r = 0 after 32 further cycles.
REQ-034 SHALL be verified by this scenario: rst_n low at step 15 of a divide -> all outputs 0 asynchronously, no done pulse; a subsequent 100 / 7 yields 14 r 2.
